// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, format encoding and XLEN helper
// for the immediate generator and its decode sub-block.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_t;

  function automatic bit xlen_ok(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instr in; imm (XLEN, sign-extended),
// fmt and illegal out. No state.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  // 32-suffixed opcodes exist only on RV64.
  localparam bit IS64 = xlen_ok(XLEN) && (XLEN == 64);

  logic [6:0]  opc;
  logic [31:0] raw;

  assign opc = instr[6:0];

  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        fmt = FMT_I;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (IS64) begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7],
               instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31], instr[19:12],
               instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      OPC_OP_32: begin
        if (IS64) fmt = FMT_R;
        else      illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Signed size cast replicates raw[31] (== instr[31]) up to XLEN-1.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on input, 2-entry skid FIFO,
// valid/ready in and out, flush, opaque tag passthrough.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  fmt_t             dec_fmt;
  logic             dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             accept;
  logic             retire;

  assign in_ready  = (count != 2'd2) && rst_n;
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready && !flush;
  assign retire    = out_valid && out_ready && !flush;

  // Outputs come straight from storage via the registered head pointer.
  assign out_imm     = imm_q[rd_ptr];
  assign out_fmt     = fmt_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];
  assign out_tag     = tag_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (accept) begin
        imm_q[wr_ptr] <= dec_imm;
        fmt_q[wr_ptr] <= dec_fmt;
        ill_q[wr_ptr] <= dec_ill;
        tag_q[wr_ptr] <= in_tag;
        wr_ptr        <= ~wr_ptr;
      end
      if (retire) rd_ptr <= ~rd_ptr;
      if (accept && !retire)      count <= count + 2'd1;
      else if (!accept && retire) count <= count - 2'd1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe at XLEN=32 and 64.
// Both instances see the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_tag = '0; out_ready = 1'b0;
    tick(); tick();
    tests++;
    if (vld32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'd0 ||
        ill32 !== 1'b0 || tag32 !== 8'h0) begin
      fails++;
      $display("FAIL reset32: v=%b imm=%h fmt=%0d ill=%b tag=%h want 0",
               vld32, imm32, fmt32, ill32, tag32);
    end
    tests++;
    if (vld64 !== 1'b0 || imm64 !== 64'h0 || rdy64 !== 1'b0) begin
      fails++;
      $display("FAIL reset64: v=%b imm=%h rdy=%b want 0", vld64, imm64, rdy64);
    end
    tests++;
    if (rdy32 !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: got %b want 0", rdy32);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (rdy32 !== 1'b1 || vld32 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b v=%b want 1 0", rdy32, vld32);
    end
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h07;
    tick();
    in_valid = 1'b0;
    tests++;
    if (vld32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || fmt32 !== 3'd2 ||
        ill32 !== 1'b0 || tag32 !== 8'h07) begin
      fails++;
      $display("FAIL addi: v=%b imm=%h fmt=%0d ill=%b tag=%h want 1 ffffffff 2 0 07",
               vld32, imm32, fmt32, ill32, tag32);
    end
    tick();
    tests++;
    if (vld32 !== 1'b0) begin
      fails++;
      $display("FAIL addi_retire: v=%b want 0", vld32);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_tag = 8'h11;
    tick();
    in_instr = 32'hFE000CE3; in_tag = 8'h12;
    tests++;
    if (vld32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || fmt32 !== 3'd3 ||
        tag32 !== 8'h11) begin
      fails++;
      $display("FAIL sw: v=%b imm=%h fmt=%0d tag=%h want 1 fffffffc 3 11",
               vld32, imm32, fmt32, tag32);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (vld32 !== 1'b1 || imm32 !== 32'hFFFFFFF8 || fmt32 !== 3'd4 ||
        tag32 !== 8'h12) begin
      fails++;
      $display("FAIL beq: v=%b imm=%h fmt=%0d tag=%h want 1 fffffff8 4 12",
               vld32, imm32, fmt32, tag32);
    end
    tick();
    tests++;
    if (vld32 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: v=%b want 0", vld32);
    end
  endtask

  task automatic test_jal_lui();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0010006F; in_tag = 8'h21;
    tick();
    in_instr = 32'h800002B7; in_tag = 8'h22;
    tests++;
    if (imm32 !== 32'h00000800 || fmt32 !== 3'd6 || vld32 !== 1'b1) begin
      fails++;
      $display("FAIL jal32: imm=%h fmt=%0d v=%b want 00000800 6 1",
               imm32, fmt32, vld32);
    end
    tests++;
    if (imm64 !== 64'h800 || fmt64 !== 3'd6 || tag64 !== 8'h21) begin
      fails++;
      $display("FAIL jal64: imm=%h fmt=%0d tag=%h want 800 6 21",
               imm64, fmt64, tag64);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (imm64 !== 64'hFFFFFFFF80000000 || fmt64 !== 3'd5) begin
      fails++;
      $display("FAIL lui64: imm=%h fmt=%0d want ffffffff80000000 5",
               imm64, fmt64);
    end
    tests++;
    if (imm32 !== 32'h80000000 || fmt32 !== 3'd5) begin
      fails++;
      $display("FAIL lui32: imm=%h fmt=%0d want 80000000 5", imm32, fmt32);
    end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFF0001B; in_tag = 8'h33;
    tick();
    in_instr = 32'hFFFFFFFF; in_tag = 8'h34;
    tests++;
    if (vld32 !== 1'b1 || ill32 !== 1'b1 || imm32 !== 32'h0 ||
        fmt32 !== 3'd0 || tag32 !== 8'h33) begin
      fails++;
      $display("FAIL opimm32_on32: v=%b ill=%b imm=%h fmt=%0d tag=%h want 1 1 0 0 33",
               vld32, ill32, imm32, fmt32, tag32);
    end
    tests++;
    if (ill64 !== 1'b0 || imm64 !== 64'hFFFFFFFFFFFFFFFF || fmt64 !== 3'd2) begin
      fails++;
      $display("FAIL opimm32_on64: ill=%b imm=%h fmt=%0d want 0 all-ones 2",
               ill64, imm64, fmt64);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (ill32 !== 1'b1 || imm32 !== 32'h0 || fmt32 !== 3'd0 ||
        tag32 !== 8'h34 || ill64 !== 1'b1 || imm64 !== 64'h0) begin
      fails++;
      $display("FAIL opc7f: ill=%b imm=%h fmt=%0d tag=%h ill64=%b imm64=%h want 1 0 0 34 1 0",
               ill32, imm32, fmt32, tag32, ill64, imm64);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    logic acc, ret;
    logic [7:0]  rtag, snap_tag;
    logic [31:0] snap_imm;
    snap_tag = '0; snap_imm = '0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00000093 | (32'(1) << 20);
    in_tag = 8'd1;
    for (int i = 0; i < 3; i++) begin
      acc = in_valid && rdy32;
      tick();
      if (acc) begin
        idx++;
        in_valid = (idx < 5);
        in_tag = 8'(idx + 1);
        in_instr = 32'h00000093 | (32'(idx + 1) << 20);
      end
      if (i == 0) begin
        snap_tag = tag32; snap_imm = imm32;
      end
    end
    tests++;
    if (idx != 2 || rdy32 !== 1'b0) begin
      fails++;
      $display("FAIL bp_fill: accepted=%0d rdy=%b want 2 0", idx, rdy32);
    end
    tests++;
    if (vld32 !== 1'b1 || tag32 !== 8'd1 || imm32 !== 32'd1) begin
      fails++;
      $display("FAIL bp_head: v=%b tag=%0d imm=%h want 1 1 1", vld32, tag32, imm32);
    end
    tests++;
    if (tag32 !== snap_tag || imm32 !== snap_imm) begin
      fails++;
      $display("FAIL bp_stable: tag=%0d imm=%h want %0d %h",
               tag32, imm32, snap_tag, snap_imm);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      acc = in_valid && rdy32;
      ret = vld32 && out_ready;
      rtag = tag32;
      tick();
      if (ret) begin
        tests++;
        if (rtag !== 8'(got + 1)) begin
          fails++;
          $display("FAIL bp_order: got tag %0d want %0d", rtag, got + 1);
        end
        got++;
      end
      if (acc) begin
        idx++;
        in_valid = (idx < 5);
        in_tag = 8'(idx + 1);
        in_instr = 32'h00000093 | (32'(idx + 1) << 20);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (got != 5 || vld32 !== 1'b0) begin
      fails++;
      $display("FAIL bp_count: retired=%0d v=%b want 5 0", got, vld32);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 8'hA1;
    tick();
    in_tag = 8'hA2;
    tick();
    tests++;
    if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin
      fails++;
      $display("FAIL flush_fill: rdy=%b v=%b want 0 1", rdy32, vld32);
    end
    in_tag = 8'hA3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
      fails++;
      $display("FAIL flush: v=%b rdy=%b want 0 1", vld32, rdy32);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (vld32 !== 1'b0) begin
        fail_flushed(tag32);
      end
    end
  endtask

  task automatic fail_flushed(input logic [7:0] t);
    fails++;
    $display("FAIL flush_leak: out_valid=1 tag=%h want out_valid=0", t);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h55;
    tick();
    in_valid = 1'b0;
    tests++;
    if (vld32 !== 1'b1 || tag32 !== 8'h55) begin
      fails++;
      $display("FAIL mid_pre: v=%b tag=%h want 1 55", vld32, tag32);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (vld32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'd0 ||
        ill32 !== 1'b0 || tag32 !== 8'h0 || rdy32 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b want all 0",
               vld32, imm32, fmt32, ill32, tag32, rdy32);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin
      fails++;
      $display("FAIL mid_release: v=%b rdy=%b want 0 1", vld32, rdy32);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_back_to_back();
    test_jal_lui();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
